// File: rtl/seg7_scan_capture_pkg.sv
// Shared seven-segment tables for the display driver and the scan capture.
// Segment order is {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG7_PAT_0     = 7'b0000001;
    localparam logic [6:0] SEG7_PAT_1     = 7'b1001111;
    localparam logic [6:0] SEG7_PAT_2     = 7'b0010010;
    localparam logic [6:0] SEG7_PAT_3     = 7'b0000110;
    localparam logic [6:0] SEG7_PAT_4     = 7'b1001100;
    localparam logic [6:0] SEG7_PAT_5     = 7'b0100100;
    localparam logic [6:0] SEG7_PAT_6     = 7'b0100000;
    localparam logic [6:0] SEG7_PAT_7     = 7'b0001111;
    localparam logic [6:0] SEG7_PAT_8     = 7'b0000000;
    localparam logic [6:0] SEG7_PAT_9     = 7'b0000100;
    localparam logic [6:0] SEG7_PAT_DASH  = 7'b1111110;
    localparam logic [6:0] SEG7_PAT_BLANK = 7'b1111111;

    localparam logic [3:0] SEG7_DASH  = 4'hA;
    localparam logic [3:0] SEG7_BLANK = 4'hF;
    localparam logic [3:0] SEG7_BAD   = 4'hE;

    // Kind of anode word seen on the bus: blanking gap, one digit, or a clash.
    typedef enum logic [1:0] {
        AN_BLANK,
        AN_ONE,
        AN_MULTI
    } an_class_e;

    function automatic an_class_e classify_anode(input logic [3:0] an);
        an_class_e cls;
        case (an)
            4'b1111:                            cls = AN_BLANK;
            4'b0111, 4'b1011, 4'b1101, 4'b1110: cls = AN_ONE;
            default:                            cls = AN_MULTI;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display bus (segments + anodes) and the rebuilt digit outputs.
interface seg7_scan_capture_if;

    logic [6:0] Led_Disp;
    logic [3:0] anode;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [3:0] bcd3;
    logic [3:0] bcd4;
    logic [3:0] digit_vld;
    logic       frame_strobe;
    logic       seg_err;
    logic       stalled;

    // Side that drives the display bus and observes the capture results.
    modport master (
        output Led_Disp, anode,
        input  bcd1, bcd2, bcd3, bcd4, digit_vld, frame_strobe, seg_err, stalled
    );

    // Capture side.
    modport slave (
        input  Led_Disp, anode,
        output bcd1, bcd2, bcd3, bcd4, digit_vld, frame_strobe, seg_err, stalled
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment pattern to code lookup; unknown patterns flag illegal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       illegal
);

    // Table lookup against the shared pattern constants.
    always_comb begin
        code    = SEG7_BAD;
        illegal = 1'b0;
        case (pattern)
            SEG7_PAT_0:     code = 4'h0;
            SEG7_PAT_1:     code = 4'h1;
            SEG7_PAT_2:     code = 4'h2;
            SEG7_PAT_3:     code = 4'h3;
            SEG7_PAT_4:     code = 4'h4;
            SEG7_PAT_5:     code = 4'h5;
            SEG7_PAT_6:     code = 4'h6;
            SEG7_PAT_7:     code = 4'h7;
            SEG7_PAT_8:     code = 4'h8;
            SEG7_PAT_9:     code = 4'h9;
            SEG7_PAT_DASH:  code = SEG7_DASH;
            SEG7_PAT_BLANK: code = SEG7_BLANK;
            default:        illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed seven-segment bus and rebuilds the four digit codes,
// with a stability filter, per-digit valid, frame strobe, error and stall flags.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic          Clk,
    input logic          reset,
    seg7_scan_capture_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);

    logic [6:0]        r_seg;
    logic [3:0]        r_an;
    logic [6:0]        prev_seg;
    logic [3:0]        prev_an;
    logic [CNT_W-1:0]  cnt;
    logic [IDLE_W-1:0] idle_cnt;

    // digit_q[i] belongs to anode[i]; index 3 is bcd1, index 0 is bcd4.
    logic [3:0][3:0]   digit_q;
    logic [3:0]        vld_q;
    logic              frame_q;
    logic              err_q;
    logic              stalled_q;

    logic              same;
    logic              accept;
    an_class_e         an_cls;
    logic [3:0]        sel;
    logic              capture;
    logic [3:0]        dec_code;
    logic              dec_illegal;

    seg7_pattern_decode u_decode (
        .pattern (r_seg),
        .code    (dec_code),
        .illegal (dec_illegal)
    );

    // Accept fires only on the single cycle the window first fills up.
    always_comb begin
        same    = ({r_seg, r_an} == {prev_seg, prev_an});
        accept  = same && (cnt == CNT_LAST);
        an_cls  = classify_anode(r_an);
        sel     = ~r_an;
        capture = accept && (an_cls == AN_ONE);
    end

    // Input registration plus one-sample history for change detection.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_seg    <= '1;
            r_an     <= '1;
            prev_seg <= '1;
            prev_an  <= '1;
        end else begin
            r_seg    <= bus.Led_Disp;
            r_an     <= bus.anode;
            prev_seg <= r_seg;
            prev_an  <= r_an;
        end
    end

    // Stability counter: restart on any change, saturate once stable.
    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!same) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit registers and the frame strobe that accompanies a bcd4 write.
    always_ff @(posedge Clk) begin
        if (reset) begin
            digit_q <= {4{SEG7_BLANK}};
            frame_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (capture && sel[i]) begin
                    digit_q[i] <= dec_code;
                end
            end
            frame_q <= capture && sel[0] && ((vld_q | sel) == 4'hF);
        end
    end

    // Sticky error: clashing anodes or an unknown segment pattern on a digit.
    always_ff @(posedge Clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept && ((an_cls == AN_MULTI) ||
                                ((an_cls == AN_ONE) && dec_illegal))) begin
            err_q <= 1'b1;
        end
    end

    // Valid bits and idle timeout; a capture in the timeout cycle takes priority.
    always_ff @(posedge Clk) begin
        if (reset) begin
            vld_q     <= '0;
            idle_cnt  <= '0;
            stalled_q <= 1'b0;
        end else if (capture) begin
            vld_q     <= vld_q | sel;
            idle_cnt  <= '0;
            stalled_q <= 1'b0;
        end else begin
            if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (idle_cnt == IDLE_LAST) begin
                vld_q     <= '0;
                stalled_q <= 1'b1;
            end
        end
    end

    assign bus.bcd1         = digit_q[3];
    assign bus.bcd2         = digit_q[2];
    assign bus.bcd3         = digit_q[1];
    assign bus.bcd4         = digit_q[0];
    assign bus.digit_vld    = vld_q;
    assign bus.frame_strobe = frame_q;
    assign bus.seg_err      = err_q;
    assign bus.stalled      = stalled_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: a run-length reference model pushes
// the expected post-edge outputs; a monitor pops and compares after each edge.
module tb_seg7_scan_capture;

    localparam int unsigned S = 4;
    localparam int unsigned T = 64;

    logic Clk   = 1'b0;
    logic reset = 1'b1;

    always #5 Clk = ~Clk;

    seg7_scan_capture_if bus ();

    seg7_scan_capture #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  vld;
        logic        frame;
        logic        err;
        logic        stalled;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state; m_bcd[i] is the digit enabled by anode[i].
    logic [3:0]  m_bcd [4];
    logic [3:0]  m_vld;
    logic        m_frame;
    logic        m_err;
    logic        m_stalled;
    int unsigned m_idle;
    logic [10:0] run_val;
    int unsigned run_len;

    logic [6:0] pats [12];

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        case (p)
            7'b0000001: return 5'h00;
            7'b1001111: return 5'h01;
            7'b0010010: return 5'h02;
            7'b0000110: return 5'h03;
            7'b1001100: return 5'h04;
            7'b0100100: return 5'h05;
            7'b0100000: return 5'h06;
            7'b0001111: return 5'h07;
            7'b0000000: return 5'h08;
            7'b0000100: return 5'h09;
            7'b1111110: return 5'h0A;
            7'b1111111: return 5'h0F;
            default:    return 5'h1E;
        endcase
    endfunction

    // Reset looks like an all-ones bus that has already been seen twice.
    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_bcd[i] = 4'hF;
        m_vld     = 4'h0;
        m_frame   = 1'b0;
        m_err     = 1'b0;
        m_stalled = 1'b0;
        m_idle    = 0;
        run_val   = 11'h7FF;
        run_len   = 2;
    endtask

    // One clock: drive pins, advance the model by one edge, queue expectation.
    task automatic step(input logic rst, input logic [6:0] seg, input logic [3:0] an);
        logic        cap;
        int unsigned nz;
        int unsigned idx;
        logic [4:0]  d;
        exp_t        e;
        @(negedge Clk);
        reset        = rst;
        bus.Led_Disp = seg;
        bus.anode    = an;
        if (rst) begin
            model_reset();
        end else begin
            cap     = 1'b0;
            m_frame = 1'b0;
            if (run_len == S + 1) begin
                nz  = 0;
                idx = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!run_val[i]) begin
                        nz++;
                        idx = i;
                    end
                end
                if (nz == 1) begin
                    d = ref_decode(run_val[10:4]);
                    m_bcd[idx] = d[3:0];
                    if (d[4]) m_err = 1'b1;
                    m_vld[idx] = 1'b1;
                    cap = 1'b1;
                    if (idx == 0 && m_vld == 4'hF) m_frame = 1'b1;
                end else if (nz > 1) begin
                    m_err = 1'b1;
                end
            end
            if (cap) begin
                m_idle    = 0;
                m_stalled = 1'b0;
            end else if (m_idle < T) begin
                m_idle++;
                if (m_idle == T) begin
                    m_vld     = 4'h0;
                    m_stalled = 1'b1;
                end
            end
            if ({seg, an} == run_val) begin
                if (run_len < S + 2) run_len++;
            end else begin
                run_val = {seg, an};
                run_len = 1;
            end
        end
        e.bcd     = {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]};
        e.vld     = m_vld;
        e.frame   = m_frame;
        e.err     = m_err;
        e.stalled = m_stalled;
        q.push_back(e);
    endtask

    task automatic hold(input logic [6:0] seg, input logic [3:0] an, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, seg, an);
    endtask

    task automatic settle();
        @(posedge Clk);
        #2;
    endtask

    task automatic check_now(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Monitor: compare every post-edge output state against the queued model.
    exp_t me;
    always @(posedge Clk) begin
        #1;
        cyc++;
        if (q.size() > 0) begin
            me = q.pop_front();
            checks++;
            if ({bus.bcd1, bus.bcd2, bus.bcd3, bus.bcd4} !== me.bcd ||
                bus.digit_vld !== me.vld || bus.frame_strobe !== me.frame ||
                bus.seg_err !== me.err || bus.stalled !== me.stalled) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d got bcd=%h vld=%b fs=%b err=%b st=%b expected bcd=%h vld=%b fs=%b err=%b st=%b",
                         cyc, {bus.bcd1, bus.bcd2, bus.bcd3, bus.bcd4}, bus.digit_vld,
                         bus.frame_strobe, bus.seg_err, bus.stalled,
                         me.bcd, me.vld, me.frame, me.err, me.stalled);
            end
        end
    end

    logic [6:0] lb_seg [4];
    logic [3:0] lb_an  [4];

    initial begin
        logic [6:0] rs;
        logic [3:0] ra;
        int unsigned r;

        pats[0]  = 7'b0000001; pats[1]  = 7'b1001111; pats[2]  = 7'b0010010;
        pats[3]  = 7'b0000110; pats[4]  = 7'b1001100; pats[5]  = 7'b0100100;
        pats[6]  = 7'b0100000; pats[7]  = 7'b0001111; pats[8]  = 7'b0000000;
        pats[9]  = 7'b0000100; pats[10] = 7'b1111110; pats[11] = 7'b1111111;
        lb_seg[0] = 7'b1111110; lb_seg[1] = 7'b1001111;
        lb_seg[2] = 7'b0000100; lb_seg[3] = 7'b1001100;
        lb_an[0]  = 4'b0111;    lb_an[1]  = 4'b1011;
        lb_an[2]  = 4'b1101;    lb_an[3]  = 4'b1110;
        bus.Led_Disp = 7'h7F;
        bus.anode    = 4'hF;
        model_reset();

        step(1'b1, 7'h7F, 4'hF);
        step(1'b1, 7'h7F, 4'hF);
        settle();
        check_now("reset_bcd", {bus.bcd1, bus.bcd2, bus.bcd3, bus.bcd4}, 16'hFFFF);
        check_now("reset_flags", {11'd0, bus.digit_vld, bus.frame_strobe}, 16'd0);

        // Loopback of "-194" with short blanking gaps between digits.
        for (int unsigned f = 0; f < 3; f++) begin
            for (int unsigned d = 0; d < 4; d++) begin
                hold(lb_seg[d], lb_an[d], 8);
                hold(7'h7F, 4'hF, 2);
            end
        end
        settle();
        check_now("loop_bcd", {bus.bcd1, bus.bcd2, bus.bcd3, bus.bcd4}, 16'hA194);
        check_now("loop_vld", {12'd0, bus.digit_vld}, 16'h000F);
        check_now("loop_err", {15'd0, bus.seg_err}, 16'd0);

        // Two-cycle glitch followed by a stable 4 on digit 1.
        hold(7'b0000000, 4'b0111, 2);
        hold(7'b1001100, 4'b0111, 10);
        settle();
        check_now("glitch_bcd1", {12'd0, bus.bcd1}, 16'h0004);
        check_now("glitch_err", {15'd0, bus.seg_err}, 16'd0);

        // Illegal segment pattern on digit 2.
        hold(7'b1010101, 4'b1011, 8);
        hold(7'h7F, 4'hF, 10);
        settle();
        check_now("illegal_bcd2", {12'd0, bus.bcd2}, 16'h000E);
        check_now("illegal_err", {15'd0, bus.seg_err}, 16'd1);

        // Two anodes low at once.
        hold(7'b0000000, 4'b0011, 8);

        // Fill all digits, then go quiet past the timeout.
        for (int unsigned d = 0; d < 4; d++) hold(pats[d + 2], lb_an[d], 8);
        hold(7'h7F, 4'hF, T + 5);
        settle();
        check_now("timeout_vld", {12'd0, bus.digit_vld}, 16'd0);
        check_now("timeout_stalled", {15'd0, bus.stalled}, 16'd1);
        hold(7'b0001111, 4'b0111, 8);
        settle();
        check_now("resume_stalled", {15'd0, bus.stalled}, 16'd0);
        check_now("resume_bcd1", {12'd0, bus.bcd1}, 16'h0007);

        // Reset pulse in the middle of a dwell.
        hold(7'b0000110, 4'b1101, 3);
        step(1'b1, 7'b0000110, 4'b1101);
        settle();
        check_now("midreset_bcd", {bus.bcd1, bus.bcd2, bus.bcd3, bus.bcd4}, 16'hFFFF);
        check_now("midreset_err", {11'd0, bus.digit_vld, bus.seg_err}, 16'd0);
        hold(7'b0000110, 4'b1101, 10);
        settle();
        check_now("midreset_bcd3", {12'd0, bus.bcd3}, 16'h0003);

        // Randomized dwells over legal/illegal patterns and anode words.
        for (int unsigned n = 0; n < 120; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80) rs = pats[$urandom_range(0, 11)];
            else        rs = 7'($urandom);
            r = $urandom_range(0, 99);
            if (r < 70)      ra = lb_an[$urandom_range(0, 3)];
            else if (r < 85) ra = 4'hF;
            else             ra = 4'($urandom);
            if ($urandom_range(0, 39) == 0) step(1'b1, rs, ra);
            if ($urandom_range(0, 29) == 0) hold(7'h7F, 4'hF, $urandom_range(T - 8, T + 8));
            hold(rs, ra, $urandom_range(1, 8));
        end
        hold(7'h7F, 4'hF, 3);
        settle();
        settle();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0 pending entries", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
